// File: rtl/dark_stats.sv
// Per-frame statistics on a raster dark-channel stream.
// Reports the brightest dark value with its coordinates, and a count of pixels at or above a threshold.
module dark_stats #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  localparam int XW = $clog2(IMG_WIDTH),
  localparam int YW = $clog2(IMG_HEIGHT),
  localparam int CW = $clog2(IMG_WIDTH * IMG_HEIGHT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] dark_in,
  input  logic [DATA_WIDTH-1:0] thresh,
  output logic                  busy,
  output logic                  frame_done,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [XW-1:0]         max_x,
  output logic [YW-1:0]         max_y,
  output logic [CW-1:0]         bright_cnt
);

  localparam logic [XW-1:0] X_LAST = XW'(IMG_WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                state_reg;
  logic [XW-1:0]         x_reg;
  logic [YW-1:0]         y_reg;
  logic [DATA_WIDTH-1:0] run_max_reg;
  logic [XW-1:0]         run_x_reg;
  logic [YW-1:0]         run_y_reg;
  logic [CW-1:0]         run_cnt_reg;
  logic [DATA_WIDTH-1:0] thresh_reg;

  logic                  first_px;
  logic                  last_px;
  logic [DATA_WIDTH-1:0] thresh_eff;
  logic                  take_max;
  logic [DATA_WIDTH-1:0] max_next;
  logic [XW-1:0]         mx_next;
  logic [YW-1:0]         my_next;
  logic [CW-1:0]         cnt_next;

  always_comb begin
    first_px   = (state_reg == IDLE);
    last_px    = (x_reg == X_LAST) && (y_reg == Y_LAST);
    // The first pixel is compared against the live threshold, since the latch only loads on this edge.
    thresh_eff = first_px ? thresh : thresh_reg;
    take_max   = first_px || (dark_in > run_max_reg);
    max_next   = take_max ? dark_in : run_max_reg;
    mx_next    = take_max ? x_reg : run_x_reg;
    my_next    = take_max ? y_reg : run_y_reg;
    cnt_next   = (first_px ? '0 : run_cnt_reg) + CW'(dark_in >= thresh_eff);
  end

  assign busy = (state_reg == ACCUM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      x_reg       <= '0;
      y_reg       <= '0;
      run_max_reg <= '0;
      run_x_reg   <= '0;
      run_y_reg   <= '0;
      run_cnt_reg <= '0;
      thresh_reg  <= '0;
      frame_done  <= 1'b0;
      max_val     <= '0;
      max_x       <= '0;
      max_y       <= '0;
      bright_cnt  <= '0;
    end else begin
      frame_done <= 1'b0;
      if (valid_in) begin
        if (first_px) thresh_reg <= thresh;
        if (last_px) begin
          max_val     <= max_next;
          max_x       <= mx_next;
          max_y       <= my_next;
          bright_cnt  <= cnt_next;
          frame_done  <= 1'b1;
          state_reg   <= IDLE;
          x_reg       <= '0;
          y_reg       <= '0;
          run_max_reg <= '0;
          run_x_reg   <= '0;
          run_y_reg   <= '0;
          run_cnt_reg <= '0;
        end else begin
          state_reg   <= ACCUM;
          run_max_reg <= max_next;
          run_x_reg   <= mx_next;
          run_y_reg   <= my_next;
          run_cnt_reg <= cnt_next;
          if (x_reg == X_LAST) begin
            x_reg <= '0;
            y_reg <= y_reg + 1'b1;
          end else begin
            x_reg <= x_reg + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dark_stats.sv
// Scoreboard bench for dark_stats on a 4x2 image: per-frame expectations are queued by the driver and checked on frame_done.
module tb_dark_stats;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] dark_in = '0;
  logic [DW-1:0] thresh = '0;
  logic          busy;
  logic          frame_done;
  logic [DW-1:0] max_val;
  logic [1:0]    max_x;
  logic [0:0]    max_y;
  logic [3:0]    bright_cnt;

  dark_stats #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .dark_in(dark_in), .thresh(thresh),
    .busy(busy), .frame_done(frame_done), .max_val(max_val), .max_x(max_x),
    .max_y(max_y), .bright_cnt(bright_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int mv;
    int mx;
    int my;
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   held_mv = 0, held_mx = 0, held_my = 0, held_cnt = 0;

  task automatic check(input string tag, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every cycle either a due result is checked or outputs must hold with no pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(frame_done), 0);
      check("rst_outs", int'(max_val) + int'(max_x) + int'(max_y) + int'(bright_cnt), 0);
      held_mv = 0; held_mx = 0; held_my = 0; held_cnt = 0;
    end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      check("done_pulse", int'(frame_done), 1);
      check("max_val", int'(max_val), exp_q[0].mv);
      check("max_x", int'(max_x), exp_q[0].mx);
      check("max_y", int'(max_y), exp_q[0].my);
      check("bright_cnt", int'(bright_cnt), exp_q[0].cnt);
      $display("frame report: max %0d at (%0d,%0d) bright %0d", max_val, max_x, max_y, bright_cnt);
      held_mv = exp_q[0].mv; held_mx = exp_q[0].mx; held_my = exp_q[0].my; held_cnt = exp_q[0].cnt;
      void'(exp_q.pop_front());
    end else begin
      check("no_pulse", int'(frame_done), 0);
      check("held", int'(max_val) * 1000000 + int'(max_x) * 100000 + int'(max_y) * 10000 + int'(bright_cnt),
            held_mv * 1000000 + held_mx * 100000 + held_my * 10000 + held_cnt);
    end
  end

  task automatic drive_px(input logic [DW-1:0] v, input logic [DW-1:0] th, input int max_gap);
    int gap;
    gap = (max_gap > 0) ? $urandom_range(max_gap, 0) : 0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
      dark_in  = $urandom_range(255, 0);
      thresh   = $urandom_range(255, 0);
    end
    @(posedge clk); #1;
    valid_in = 1'b1;
    dark_in  = v;
    thresh   = th;
  endtask

  // Drives one full frame and queues its expected report, due one cycle after the last pixel.
  task automatic run_frame(input logic [DW-1:0] px[N], input logic [DW-1:0] th[N], input int max_gap);
    exp_t e;
    int   lat;
    e.mv = px[0]; e.mx = 0; e.my = 0; e.cnt = 0;
    lat = th[0];
    for (int i = 0; i < N; i++) begin
      if (int'(px[i]) > e.mv) begin
        e.mv = px[i]; e.mx = i % W; e.my = i / W;
      end
      if (int'(px[i]) >= lat) e.cnt++;
      drive_px(px[i], th[i], max_gap);
      if (i == N - 1) begin
        e.due = cyc + 1;
        exp_q.push_back(e);
      end
    end
    $display("frame driven: expect max %0d at (%0d,%0d) bright %0d", e.mv, e.mx, e.my, e.cnt);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b0;
    end
  endtask

  logic [DW-1:0] px[N];
  logic [DW-1:0] th[N];

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Ramp, back-to-back, thresh 50.
    px = '{10, 20, 30, 40, 50, 60, 70, 80};
    th = '{50, 50, 50, 50, 50, 50, 50, 50};
    run_frame(px, th, 0);
    idle(3);

    // Tie on 90 keeps the earliest pixel, random gaps.
    px = '{5, 90, 3, 90, 1, 1, 1, 1};
    th = '{50, 50, 50, 50, 50, 50, 50, 50};
    run_frame(px, th, 3);
    idle(3);

    // Threshold dropped mid-frame, then a second frame starting in the frame_done cycle.
    px = '{10, 20, 30, 40, 50, 60, 70, 80};
    th = '{50, 50, 0, 0, 0, 0, 0, 0};
    run_frame(px, th, 0);
    px = '{7, 7, 7, 7, 7, 7, 7, 7};
    th = '{8, 8, 8, 8, 8, 8, 8, 8};
    run_frame(px, th, 0);
    idle(3);

    // All-equal frame with thresh 0 counts every pixel.
    px = '{33, 33, 33, 33, 33, 33, 33, 33};
    th = '{0, 0, 0, 0, 0, 0, 0, 0};
    run_frame(px, th, 2);
    idle(3);

    // Abort after five pixels with reset, then a clean frame.
    for (int i = 0; i < 5; i++) drive_px(DW'(100 + i), 8'd0, 0);
    @(posedge clk); #1;
    valid_in = 1'b0;
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);
    px = '{200, 200, 200, 200, 200, 200, 200, 200};
    th = '{200, 200, 200, 200, 200, 200, 200, 200};
    run_frame(px, th, 1);
    idle(4);

    @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    check("idle_busy", int'(busy), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
